// File: rtl/module_input_debounce_pkg.sv
// Shared constants and helpers for the Gray-code switch input path.
// Provides the default debounce length and a bit-count helper.
package pkg_deco_gray;

  localparam int unsigned CLK_FREQ_HZ   = 32'd27000000;
  localparam int unsigned DEBOUNCE_MS   = 32'd10;
  localparam int unsigned STABLE_CYCLES = (CLK_FREQ_HZ / 32'd1000) * DEBOUNCE_MS;

  // Switch vectors up to POP_MAX_W bits wide are zero-extended before counting.
  localparam int unsigned POP_MAX_W = 32'd32;

  function automatic logic [5:0] popcount(input logic [POP_MAX_W-1:0] vec);
    logic [5:0] ones;
    ones = 6'd0;
    for (int i = 0; i < POP_MAX_W; i++) begin
      ones = ones + {5'd0, vec[i]};
    end
    return ones;
  endfunction

endpackage

// File: rtl/module_sync_2ff.sv
// Two-flop synchroniser for asynchronous inputs.
// Synchronous active-high reset clears both stages.
module module_sync_2ff #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] sync1_r;
  logic [WIDTH-1:0] sync2_r;

  // Metastability chain: the second flop samples the first directly.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_r <= {WIDTH{1'b0}};
      sync2_r <= {WIDTH{1'b0}};
    end else begin
      sync1_r <= d_i;
      sync2_r <= sync1_r;
    end
  end

  assign q_o = sync2_r;

endmodule

// File: rtl/module_input_debounce.sv
// Synchronises and debounces the raw Gray switch vector as one unit, strobing
// each accepted update and counting updates that change more than one bit.
module module_input_debounce
  import pkg_deco_gray::*;
#(
  parameter int unsigned WIDTH         = 4,
  parameter int unsigned STABLE_CYCLES = pkg_deco_gray::STABLE_CYCLES,
  parameter int unsigned ERR_CNT_W     = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [WIDTH-1:0]     raw_i,
  output logic [WIDTH-1:0]     data_o,
  output logic                 valid_o,
  output logic                 multibit_o,
  output logic                 stable_o,
  output logic [ERR_CNT_W-1:0] err_cnt_o
);

  localparam int unsigned CNT_W = (STABLE_CYCLES > 32'd1) ? $clog2(STABLE_CYCLES) : 32'd1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 32'd1);

  logic [WIDTH-1:0] sq_s;
  logic [WIDTH-1:0] cand_r;
  logic [CNT_W-1:0] cnt_r;
  logic             multi_s;
  logic             err_sat_s;

  module_sync_2ff #(
    .WIDTH (WIDTH)
  ) u_sync (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .d_i   (raw_i),
    .q_o   (sq_s)
  );

  // Classify the pending update against the currently published value.
  always_comb begin
    multi_s   = 1'b0;
    err_sat_s = &err_cnt_o;
    if (popcount(POP_MAX_W'(cand_r ^ data_o)) > 6'd1) begin
      multi_s = 1'b1;
    end else begin
      multi_s = 1'b0;
    end
  end

  // Any change of the synchronised vector restarts the count; a full count publishes it.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cand_r     <= {WIDTH{1'b0}};
      cnt_r      <= {CNT_W{1'b0}};
      data_o     <= {WIDTH{1'b0}};
      valid_o    <= 1'b0;
      multibit_o <= 1'b0;
      stable_o   <= 1'b0;
      err_cnt_o  <= {ERR_CNT_W{1'b0}};
    end else begin
      valid_o    <= 1'b0;
      multibit_o <= 1'b0;
      if (sq_s != cand_r) begin
        cand_r   <= sq_s;
        cnt_r    <= {CNT_W{1'b0}};
        stable_o <= 1'b0;
      end else if (cnt_r < CNT_MAX) begin
        cnt_r <= cnt_r + CNT_W'(1);
      end else begin
        stable_o <= 1'b1;
        // Settling back on the published value is not a new update.
        if (cand_r != data_o) begin
          data_o     <= cand_r;
          valid_o    <= 1'b1;
          multibit_o <= multi_s;
          if (multi_s && !err_sat_s) begin
            err_cnt_o <= err_cnt_o + ERR_CNT_W'(1);
          end
        end
      end
    end
  end

endmodule
